// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the direct-mapped write-through data cache.
package dcache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StRefill,
        StWrite,
        StRespond
    } state_e;

    function automatic int unsigned index_width(int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int unsigned woff_width(int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned tag_width(int unsigned num_lines, int unsigned line_words);
        return 32 - $clog2(num_lines) - $clog2(line_words) - 2;
    endfunction

    // Field extractors return right-justified 32-bit values; callers size-cast to the field width.
    function automatic logic [31:0] addr_tag(logic [31:0] addr, int unsigned index_w,
                                             int unsigned woff_w);
        return addr >> (index_w + woff_w + 2);
    endfunction

    function automatic logic [31:0] addr_index(logic [31:0] addr, int unsigned index_w,
                                               int unsigned woff_w);
        return (addr >> (woff_w + 2)) & ((32'd1 << index_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_word(logic [31:0] addr, int unsigned woff_w);
        return (addr >> 2) & ((32'd1 << woff_w) - 32'd1);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read by index, byte-enabled data write, tag/valid update.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned INDEX_W    = index_width(NUM_LINES),
    parameter int unsigned WOFF_W     = woff_width(LINE_WORDS),
    parameter int unsigned TAG_W      = tag_width(NUM_LINES, LINE_WORDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] index,
    input  logic [WOFF_W-1:0]  rd_word,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [31:0]        rd_data,
    input  logic               data_we,
    input  logic [WOFF_W-1:0]  wr_word,
    input  logic [3:0]         wr_be,
    input  logic [31:0]        wr_data,
    input  logic               tag_we,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               wr_valid
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES*LINE_WORDS];

    logic [INDEX_W+WOFF_W-1:0] rd_addr;
    logic [INDEX_W+WOFF_W-1:0] wr_addr;

    assign rd_addr  = {index, rd_word};
    assign wr_addr  = {index, wr_word};
    assign rd_valid = valid_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_data  = data_q[rd_addr];

    // Valid bits are the only storage that needs a reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[index] <= wr_valid;
        end
    end

    // Tag update alongside the valid bit.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[index] <= wr_tag;
        end
    end

    // Byte-lane data write.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (data_we && wr_be[b]) begin
                data_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with word-by-word line refill.
module dcache
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PStrobe,
    input  logic [31:0] p_addr,
    input  logic [3:0]  p_w_en,
    input  logic [31:0] p_wdata,
    output logic        PReady,
    output logic [31:0] p_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned INDEX_W = index_width(NUM_LINES);
    localparam int unsigned WOFF_W  = woff_width(LINE_WORDS);
    localparam int unsigned TAG_W   = tag_width(NUM_LINES, LINE_WORDS);

    state_e state_q, state_d;

    logic [31:0]       addr_q;
    logic [3:0]        wen_q;
    logic [31:0]       wdata_q;
    logic [WOFF_W-1:0] cnt_q;
    logic [31:0]       p_rdata_q;
    // Marks the settle cycle after the final transfer: mem_req is low, the line update lands.
    logic              done_q;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [WOFF_W-1:0]  req_word;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [31:0]       rd_data;
    logic              data_we;
    logic [WOFF_W-1:0] wr_word;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;
    logic              tag_we;
    logic              wr_valid;

    logic hit;
    logic is_load;
    logic last_beat;
    logic beat_done;
    logic write_done;

    assign req_tag    = TAG_W'(addr_tag(addr_q, INDEX_W, WOFF_W));
    assign req_index  = INDEX_W'(addr_index(addr_q, INDEX_W, WOFF_W));
    assign req_word   = WOFF_W'(addr_word(addr_q, WOFF_W));
    assign hit        = rd_valid && (rd_tag == req_tag);
    assign is_load    = (wen_q == 4'b0000);
    assign last_beat  = (cnt_q == WOFF_W'(LINE_WORDS - 1));
    assign beat_done  = (state_q == StRefill) && !done_q && mem_ready;
    assign write_done = (state_q == StWrite) && !done_q && mem_ready;
    assign p_rdata    = p_rdata_q;

    dcache_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .INDEX_W    (INDEX_W),
        .WOFF_W     (WOFF_W),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .index    (req_index),
        .rd_word  (req_word),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .data_we  (data_we),
        .wr_word  (wr_word),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .tag_we   (tag_we),
        .wr_tag   (req_tag),
        .wr_valid (wr_valid)
    );

    // Array write port: store-hit merge in LOOKUP, full-word fill during REFILL.
    always_comb begin
        data_we  = 1'b0;
        wr_word  = req_word;
        wr_be    = wen_q;
        wr_data  = wdata_q;
        tag_we   = 1'b0;
        wr_valid = 1'b0;
        if (state_q == StLookup) begin
            data_we = !is_load && hit;
            // Invalidate on refill entry so a partially filled line never hits.
            tag_we  = is_load && !hit;
        end else if (state_q == StRefill) begin
            data_we  = beat_done;
            wr_word  = cnt_q;
            wr_be    = 4'hF;
            wr_data  = mem_rdata;
            tag_we   = done_q;
            wr_valid = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (PStrobe) state_d = StLookup;
            StLookup: begin
                if (!is_load)  state_d = StWrite;
                else if (hit)  state_d = StRespond;
                else           state_d = StRefill;
            end
            StRefill:  if (done_q) state_d = StRespond;
            StWrite:   if (done_q) state_d = StRespond;
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs decoded from the state register and registered request fields.
    always_comb begin
        PReady    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_be    = 4'h0;
        mem_wdata = 32'h0;
        case (state_q)
            StRefill: begin
                mem_req  = !done_q;
                mem_addr = done_q ? 32'h0 : {req_tag, req_index, cnt_q, 2'b00};
            end
            StWrite: begin
                mem_req   = !done_q;
                mem_we    = !done_q;
                mem_addr  = done_q ? 32'h0 : (addr_q & 32'hFFFF_FFFC);
                mem_be    = done_q ? 4'h0 : wen_q;
                mem_wdata = done_q ? 32'h0 : wdata_q;
            end
            StRespond: PReady = 1'b1;
            default: ;
        endcase
    end

    // Request capture, refill counter and load-data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= 32'h0;
            wen_q     <= 4'h0;
            wdata_q   <= 32'h0;
            cnt_q     <= '0;
            p_rdata_q <= 32'h0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (beat_done && last_beat) || write_done;
            if (state_q == StIdle && PStrobe) begin
                addr_q  <= p_addr;
                wen_q   <= p_w_en;
                wdata_q <= p_wdata;
            end
            if (state_q == StLookup) begin
                cnt_q <= '0;
                if (is_load && hit) begin
                    p_rdata_q <= rd_data;
                end
            end
            if (beat_done) begin
                cnt_q <= cnt_q + WOFF_W'(1);
                if (cnt_q == req_word) begin
                    p_rdata_q <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Directed self-checking bench for dcache with a behavioural word memory.
module tb_dcache;

    logic        clk = 1'b0;
    logic        rst;
    logic        PStrobe;
    logic [31:0] p_addr;
    logic [3:0]  p_w_en;
    logic [31:0] p_wdata;
    logic        PReady;
    logic [31:0] p_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [4096];
    int          latency  = 0;
    int          wait_cnt = 0;
    int          n_rd;
    int          n_wr;
    logic [31:0] rd_log [$];
    logic [31:0] wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;

    logic        prev_req   = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_we    = 1'b0;
    logic [31:0] prev_addr  = 32'h0;

    int          lat;
    logic [31:0] rd;

    dcache #(
        .NUM_LINES  (16),
        .LINE_WORDS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PStrobe   (PStrobe),
        .p_addr    (p_addr),
        .p_w_en    (p_w_en),
        .p_wdata   (p_wdata),
        .PReady    (PReady),
        .p_rdata   (p_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Memory responder and request-stability monitor, evaluated away from the active edge.
    always @(negedge clk) begin
        if (mem_req && prev_req && !prev_ready) begin
            check("mem_addr_stable", mem_addr, prev_addr);
            check("mem_we_stable", {31'b0, mem_we}, {31'b0, prev_we});
        end
        prev_req  = mem_req;
        prev_addr = mem_addr;
        prev_we   = mem_we;
        mem_ready = 1'b0;
        if (mem_req) begin
            if (wait_cnt >= latency) begin
                mem_ready = 1'b1;
                wait_cnt  = 0;
                if (mem_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be[b]) mem[mem_addr[13:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                    n_wr++;
                    wr_addr = mem_addr;
                    wr_be   = mem_be;
                    wr_data = mem_wdata;
                end else begin
                    mem_rdata = mem[mem_addr[13:2]];
                    n_rd++;
                    rd_log.push_back(mem_addr);
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        prev_ready = mem_ready;
    end

    task automatic clear_log();
        n_rd = 0;
        n_wr = 0;
        rd_log.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_PReady"}, {31'b0, PReady}, 32'h0);
        check({tag, "_mem_req"}, {31'b0, mem_req}, 32'h0);
        check({tag, "_mem_we"}, {31'b0, mem_we}, 32'h0);
        check({tag, "_mem_be"}, {28'b0, mem_be}, 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_p_rdata"}, p_rdata, 32'h0);
    endtask

    // One CPU access: strobe for a cycle, then count cycles until PReady (bounded).
    task automatic access(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                          output int l, output logic [31:0] r);
        @(posedge clk);
        #1;
        check("preceding_PReady_low", {31'b0, PReady}, 32'h0);
        PStrobe = 1'b1;
        p_addr  = a;
        p_w_en  = be;
        p_wdata = d;
        @(posedge clk);
        #1;
        PStrobe = 1'b0;
        l = 1;
        @(negedge clk);
        while (!PReady && l < 200) begin
            @(negedge clk);
            l++;
        end
        r = p_rdata;
    endtask

    initial begin
        int pr_cnt;
        int first;
        logic [31:0] rdv;
        logic [31:0] conf_addr [3];

        rst     = 1'b0;
        PStrobe = 1'b0;
        p_addr  = 32'h0;
        p_w_en  = 4'h0;
        p_wdata = 32'h0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 | (i << 2);
        clear_log();
        #1;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Cold load refills the whole line.
        clear_log();
        access(32'h100, 4'h0, 32'h0, lat, rd);
        check("cold_lat", lat, 7);
        check("cold_rdata", rd, 32'hC0DE_0100);
        check("cold_nrd", n_rd, 4);
        if (rd_log.size() == 4) begin
            for (int k = 0; k < 4; k++) check("cold_addr", rd_log[k], 32'h100 + 32'(k * 4));
        end

        // Repeat load in the same line hits.
        clear_log();
        access(32'h104, 4'h0, 32'h0, lat, rd);
        check("hit_lat", lat, 2);
        check("hit_rdata", rd, 32'hC0DE_0104);
        check("hit_nrd", n_rd, 0);

        // Store hit merges one byte and writes through.
        clear_log();
        access(32'h108, 4'b0010, 32'h0000_AB00, lat, rd);
        check("sthit_lat", lat, 4);
        check("sthit_nwr", n_wr, 1);
        check("sthit_addr", wr_addr, 32'h108);
        check("sthit_be", {28'b0, wr_be}, 32'h2);
        check("sthit_data", wr_data, 32'h0000_AB00);
        clear_log();
        access(32'h108, 4'h0, 32'h0, lat, rd);
        check("sthit_ld_lat", lat, 2);
        check("sthit_ld_rdata", rd, 32'hC0DE_AB08);
        check("sthit_ld_nrd", n_rd, 0);

        // Store miss writes memory only; the following load misses.
        clear_log();
        access(32'h2000, 4'hF, 32'h1234_5678, lat, rd);
        check("stmiss_lat", lat, 4);
        check("stmiss_nwr", n_wr, 1);
        check("stmiss_addr", wr_addr, 32'h2000);
        check("stmiss_nrd", n_rd, 0);
        clear_log();
        access(32'h2000, 4'h0, 32'h0, lat, rd);
        check("stmiss_ld_lat", lat, 7);
        check("stmiss_ld_rdata", rd, 32'h1234_5678);
        check("stmiss_ld_nrd", n_rd, 4);
        if (rd_log.size() == 4) begin
            check("stmiss_ld_first", rd_log[0], 32'h2000);
            check("stmiss_ld_last", rd_log[3], 32'h200C);
        end

        // Conflict eviction on index 0.
        conf_addr[0] = 32'h100;
        conf_addr[1] = 32'h500;
        conf_addr[2] = 32'h100;
        clear_log();
        for (int k = 0; k < 3; k++) begin
            access(conf_addr[k], 4'h0, 32'h0, lat, rd);
            check("conf_lat", lat, 7);
            check("conf_rdata", rd, 32'hC0DE_0000 | conf_addr[k]);
        end
        check("conf_nrd", n_rd, 12);

        // Three wait states per word, with stray strobes while busy.
        clear_log();
        latency = 3;
        @(posedge clk);
        #1;
        PStrobe = 1'b1;
        p_addr  = 32'h304;
        p_w_en  = 4'h0;
        pr_cnt  = 0;
        first   = -1;
        rdv     = 32'h0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            p_addr  = 32'h700;
            PStrobe = (c == 5 || c == 9 || c == 13);
            @(negedge clk);
            if (PReady) begin
                pr_cnt++;
                if (first < 0) begin
                    first = c;
                    rdv   = p_rdata;
                end
            end
        end
        PStrobe = 1'b0;
        latency = 0;
        check("wait_lat", first, 19);
        check("wait_preday_cycles", pr_cnt, 1);
        check("wait_rdata", rdv, 32'hC0DE_0304);
        check("wait_nrd", n_rd, 4);
        check("wait_nwr", n_wr, 0);

        // Fill line 1 so the reset's valid clear is observable there.
        access(32'h010, 4'h0, 32'h0, lat, rd);
        check("l1_fill_lat", lat, 7);

        // Reset after the second refill word.
        clear_log();
        @(posedge clk);
        #1;
        PStrobe = 1'b1;
        p_addr  = 32'h900;
        @(posedge clk);
        #1;
        PStrobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_nrd", n_rd, 2);
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        pr_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (PReady || mem_req) pr_cnt++;
        end
        check("rst_idle_after", pr_cnt, 0);
        clear_log();
        access(32'h010, 4'h0, 32'h0, lat, rd);
        check("rst_l1_lat", lat, 7);
        check("rst_l1_rdata", rd, 32'hC0DE_0010);
        clear_log();
        access(32'h900, 4'h0, 32'h0, lat, rd);
        check("rst_refill_lat", lat, 7);
        check("rst_refill_rdata", rd, 32'hC0DE_0900);
        check("rst_refill_nrd", n_rd, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
